// File: rtl/noc_pipe_pkg.sv
// Shared definitions for the NoC elastic pipeline register:
// default geometry, count width helper and a per-stage record.
package noc_pipe_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;

  // Width that can represent every occupancy from 0 to depth.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
  } stage_t;

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register pair of the elastic pipeline; loads from its
// predecessor whenever its advance input is high.
module pipe_stage
  import noc_pipe_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter bit ZERO_INVALID = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_adv,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // With ZERO_INVALID an empty stage always carries zero data; otherwise
  // data only changes when a real word lands here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      if (ZERO_INVALID) r_data <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      if (i_valid)           r_data <= i_data;
      else if (ZERO_INVALID) r_data <= '0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/noc_pipe_reg.sv
// Elastic NoC pipeline register: DEPTH valid/ready stages with bubble
// collapsing, flush and an occupancy count.
module noc_pipe_reg
  import noc_pipe_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter bit ZERO_INVALID = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_src_v;
  logic [WIDTH-1:0] w_d     [DEPTH];
  logic [WIDTH-1:0] w_src_d [DEPTH];

  // Ready ripples back from the output; any empty stage breaks the stall.
  always_comb begin
    w_adv            = '0;
    w_adv[DEPTH-1]   = ~w_v[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_adv[i] = ~w_v[i] | w_adv[i+1];
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign w_src_v[gi] = in_valid & ~flush;
      assign w_src_d[gi] = in_data;
    end else begin : g_link
      assign w_src_v[gi] = w_v[gi-1];
      assign w_src_d[gi] = w_d[gi-1];
    end

    pipe_stage #(
      .WIDTH        (WIDTH),
      .ZERO_INVALID (ZERO_INVALID)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .i_adv   (w_adv[gi]),
      .i_flush (flush),
      .i_valid (w_src_v[gi]),
      .i_data  (w_src_d[gi]),
      .o_valid (w_v[gi]),
      .o_data  (w_d[gi])
    );
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CNT_W'(w_v[i]);
    end
  end

  assign in_ready  = w_adv[0] & ~flush;
  assign out_valid = w_v[DEPTH-1];
  assign out_data  = w_d[DEPTH-1];

endmodule

// File: tb/tb_noc_pipe_reg.sv
// Scoreboard bench for noc_pipe_reg (DEPTH=3) plus a ZERO_INVALID=0 instance.
module tb_noc_pipe_reg;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count;

  logic       z_flush;
  logic [7:0] z_in_data;
  logic       z_in_valid;
  logic       z_in_ready;
  logic [7:0] z_out_data;
  logic       z_out_valid;
  logic       z_out_ready;
  logic [1:0] z_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb_q[$];

  noc_pipe_reg #(.WIDTH(8), .DEPTH(3), .ZERO_INVALID(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  noc_pipe_reg #(.WIDTH(8), .DEPTH(3), .ZERO_INVALID(1'b0)) dut_z (
    .clk(clk), .reset(reset), .flush(z_flush),
    .in_data(z_in_data), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .out_data(z_out_data), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .count(z_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int max_cyc);
    int n;
    n = 0;
    while (!out_valid && n < max_cyc) begin
      tick();
      n++;
    end
    chk("wait_out_valid", out_valid, 1);
  endtask

  // Transfers are decided by the values stable across the coming edge.
  always @(negedge clk) begin
    if (!reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_word_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          $display("deliver data=0x%02h expected=0x%02h", out_data, sb_q[0]);
          chk("sb_data", out_data, sb_q.pop_front());
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(in_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    z_flush = 1'b0; z_in_data = '0; z_in_valid = 1'b0; z_out_ready = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    flush = 1'b1;
    #1 chk("rst_in_ready_flush", in_ready, 0);
    flush = 1'b0;
    in_valid = 1'b1; in_data = 8'hEE;
    tick();
    chk("rst_hold_count", count, 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    tick();

    // Streaming with out_ready high
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    chk("stream_count1", count, 1);
    in_data = 8'h22;
    tick();
    chk("stream_lat_early", out_valid, 0);
    in_data = 8'h33;
    tick();
    chk("stream_lat_valid", out_valid, 1);
    chk("stream_first", out_data, 8'h11);
    chk("stream_peak", count, 3);
    in_data = 8'h44;
    tick();
    chk("stream_peak2", count, 3);
    in_valid = 1'b0;
    repeat (3) tick();
    chk("stream_empty", count, 0);
    chk("stream_zero_data", out_data, 0);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 8'hA0 + 8'(i);
      tick();
    end
    in_data = 8'hA4;
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_count_full", count, 3);
    tick();
    chk("bp_hold_count", count, 3);
    chk("bp_hold_data", out_data, 8'hA1);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_pop", in_ready, 1);
    tick();
    chk("bp_push_pop_count", count, 3);
    chk("bp_next_data", out_data, 8'hA2);
    in_valid = 1'b0;
    repeat (3) tick();
    chk("bp_drained", count, 0);

    // Bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    in_valid = 1'b1; in_data = 8'h66;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bubble_occupancy", dut.w_v, 3'b110);
    chk("bubble_count", count, 2);
    chk("bubble_out", out_data, 8'h55);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("bubble_drained", count, 0);

    // Flush a full pipeline
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_data = 8'h99; flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_out_valid", out_valid, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_out_valid_after", out_valid, 0);
    chk("flush_out_data", out_data, 0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("flush_no_99", out_valid, 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hC1; tick();
    in_data = 8'hC2; tick();
    in_valid = 1'b0;
    chk("arst_pre_count", count, 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_out_data", out_data, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    in_valid = 1'b1; in_data = 8'h7E; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(10);
    chk("arst_first_word", out_data, 8'h7E);
    repeat (3) tick();
    chk("arst_drained", count, 0);

    // ZERO_INVALID=0 keeps stale data
    z_out_ready = 1'b1;
    z_in_valid = 1'b1; z_in_data = 8'h5A;
    tick();
    z_in_valid = 1'b0;
    repeat (2) tick();
    chk("zi0_valid", z_out_valid, 1);
    chk("zi0_data", z_out_data, 8'h5A);
    tick();
    chk("zi0_idle_valid", z_out_valid, 0);
    chk("zi0_idle_data", z_out_data, 8'h5A);
    chk("zi0_count", z_count, 0);

    chk("sb_all_delivered", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/noc_pipe_reg.md
NOC_PIPE_REG -- requirements
Module: noc_pipe_reg

Interface
REQ-001 Parameter WIDTH, default 8: data bits per stage; legal range is WIDTH >= 1.
REQ-002 Parameter DEPTH, default 2: number of register stages; legal range is DEPTH >= 1.
REQ-003 Parameter ZERO_INVALID, default 1: 1 means an empty stage's data reads 0, 0 means an empty stage's data holds its last value.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port flush, input, 1 bit: discard all pipeline contents.
REQ-007 Port in_data, input, WIDTH bits: upstream data.
REQ-008 Port in_valid, input, 1 bit: upstream data valid.
REQ-009 Port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-010 Port out_data, output, WIDTH bits: last-stage data.
REQ-011 Port out_valid, output, 1 bit: last-stage valid.
REQ-012 Port out_ready, input, 1 bit: downstream accepts this cycle.
REQ-013 Port count, output, $clog2(DEPTH+1) bits: number of occupied stages.

Function
REQ-014 Stage i holds v[i] and d[i]; stage 0 is nearest the input; out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
REQ-015 Advance condition: adv[DEPTH-1] = ~v[DEPTH-1] | out_ready; adv[i] = ~v[i] | adv[i+1] for i < DEPTH-1 (combinational ready chain).
REQ-016 in_ready = adv[0] & ~flush; a transfer occurs when in_valid & in_ready.
REQ-017 When adv[i] is high at posedge clk: v[i] <= v[i-1] and d[i] <= d[i-1]; for stage 0 the sources are (in_valid & ~flush) and in_data.
REQ-018 When adv[i] is low, stage i holds v[i] and d[i].
REQ-019 Bubbles collapse: an empty stage always accepts from its predecessor regardless of downstream state.
REQ-020 Throughput is 1 word per cycle when out_ready is held high.
REQ-021 Latency: a word accepted at edge t is presented on out_* in the cycle after edge t+DEPTH-1, provided no stall occurs.
REQ-022 Ordering is strictly FIFO; there is no duplication or loss except by flush.
REQ-023 Flush high at posedge clk clears every v[i] to 0.
REQ-024 While flush is high, in_ready = 0 and no input is accepted.
REQ-025 out_valid in a flush cycle still reflects current contents; a word with out_valid & out_ready high in that cycle counts as delivered.
REQ-026 ZERO_INVALID = 1: any stage whose next v is 0 loads d = 0 at that edge, including on flush.
REQ-027 ZERO_INVALID = 0: d loads only when the stage loads a valid word; it is otherwise held.
REQ-028 count = popcount(v) (combinational); count = 0 when empty and DEPTH when full.
REQ-029 Full with out_ready low: in_ready = 0 and all stages hold.
REQ-030 Simultaneous push and pop when full: both occur in the same cycle and count is unchanged.

Reset
REQ-031 While reset = 0: all v[i] = 0 and all d[i] = 0, asynchronously, regardless of clk.
REQ-032 Output values under reset: out_valid = 0, out_data = 0, count = 0, in_ready = ~flush.
REQ-033 Reset asserted mid-stream discards all words; after reset deasserts, the next accepted word is the first delivered.
REQ-034 Reset deassertion takes effect at the first posedge clk after reset rises.

Structure
REQ-035 Shared package noc_pipe_pkg holds DEF_WIDTH, DEF_DEPTH, the count-width function, and a stage struct typedef {valid, data}.
REQ-036 A single sub-module pipe_stage (one v/d register pair with adv, flush and async reset) is instantiated DEPTH times via generate.
REQ-037 pipe_stage implements ZERO_INVALID locally.

Verification (WIDTH=8, DEPTH=3, ZERO_INVALID=1 unless stated)
REQ-038 Streaming: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with out_ready=1 -> same sequence on out_data, first word 3 cycles after its acceptance cycle, count peaks at 3.
REQ-039 Backpressure: out_ready=0, push 0xA1..0xA4 -> 3 accepted, in_ready=0 on the 4th with count=3; raise out_ready -> 0xA1, 0xA2, 0xA3, 0xA4 delivered in order.
REQ-040 Bubble collapse: push 0x55, idle 2 cycles, push 0x66 with out_ready=0 -> stage occupancy compacts toward the output and count=2.
REQ-041 Flush: pipeline full (0x01, 0x02, 0x03), assert flush 1 cycle with in_valid=1, in_data=0x99 -> next cycle count=0, out_valid=0, out_data=0x00, and 0x99 is never delivered.
REQ-042 Async reset mid-stream: drop reset between clock edges while count=2 -> out_valid=0 and count=0 immediately; after release, a push of 0x7E is the first output.
REQ-043 ZERO_INVALID=0: deliver 0x5A, then idle -> out_valid=0 and out_data stays 0x5A.
